// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types and constants for the LIF layer
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] LD_INPUTS  = 2'd0;
  localparam logic [1:0] LD_WEIGHTS = 2'd1;
  localparam logic [1:0] LD_CONFIG  = 2'd2;
  localparam logic [1:0] LD_THRESH  = 2'd3;

  localparam int           THRESH_INIT = 5;
  localparam logic [255:0] WEIGHT_INIT = '1;

endpackage

// File: rtl/lif_update.sv
// rtl/lif_update.sv - combinational single-neuron leak/integrate/fire step
module lif_update
  import lif_pkg::*;
#(
  parameter int SYNAPSES       = 32,
  parameter int MEMBRANE_BITS  = 8,
  parameter int THRESHOLD_BITS = 6,
  parameter int REFRACTORY     = 2,
  parameter int CW             = 2
) (
  input  logic [SYNAPSES-1:0]              i_inputs,
  input  logic [SYNAPSES-1:0]              i_weights,
  input  logic signed [MEMBRANE_BITS-1:0]  i_mem,
  input  logic [2:0]                       i_shift,
  input  logic                             i_mode,
  input  logic [THRESHOLD_BITS-1:0]        i_thresh,
  input  logic [CW-1:0]                    i_ref,
  output logic signed [MEMBRANE_BITS-1:0]  o_mem,
  output logic                             o_spike,
  output logic [CW-1:0]                    o_ref
);

  localparam int MB = MEMBRANE_BITS;
  localparam int SW = $clog2(SYNAPSES) + 2;
  localparam int VW = ((MB > SW) ? MB : SW) + 1;

  logic [SW-1:0]        w_pos;
  logic [SW-1:0]        w_neg;
  logic signed [SW-1:0] w_sum;
  logic signed [MB-1:0] w_leak;
  logic signed [VW-1:0] w_raw;
  logic                 w_ovf;
  logic signed [MB-1:0] w_v;
  logic signed [MB-1:0] w_thr_ext;
  logic                 w_fire;

  // Count agreeing (+1) and opposing (-1) active synapses.
  always_comb begin
    w_pos = '0;
    w_neg = '0;
    for (int b = 0; b < SYNAPSES; b++) begin
      w_pos = w_pos + SW'(i_inputs[b] & i_weights[b]);
      w_neg = w_neg + SW'(i_inputs[b] & ~i_weights[b]);
    end
  end

  assign w_sum  = $signed(w_pos) - $signed(w_neg);
  assign w_leak = (i_shift == 3'd0) ? i_mem : i_mem - (i_mem >>> i_shift);
  assign w_raw  = {{(VW-MB){w_leak[MB-1]}}, w_leak} + {{(VW-SW){w_sum[SW-1]}}, w_sum};

  // Result fits in MB bits only when all bits above the MB sign bit match it.
  assign w_ovf = !((&w_raw[VW-1:MB-1]) || !(|w_raw[VW-1:MB-1]));
  assign w_v   = w_ovf ? (w_raw[VW-1] ? {1'b1, {(MB-1){1'b0}}} : {1'b0, {(MB-1){1'b1}}})
                       : w_raw[MB-1:0];

  assign w_thr_ext = {{(MB-THRESHOLD_BITS){1'b0}}, i_thresh};
  assign w_fire    = (w_v >= w_thr_ext);

  // Refractory neurons only leak; otherwise integrate, fire and reset/subtract.
  always_comb begin
    o_mem   = w_v;
    o_spike = 1'b0;
    o_ref   = i_ref;
    if (i_ref != '0) begin
      o_mem = w_leak;
      o_ref = i_ref - CW'(1);
    end else if (w_fire) begin
      o_spike = 1'b1;
      o_ref   = CW'(REFRACTORY);
      o_mem   = i_mode ? (w_v - w_thr_ext) : '0;
    end
  end

endmodule

// File: rtl/lif_layer.sv
// rtl/lif_layer.sv - time-multiplexed layer of LIF neurons with byte loader
module lif_layer
  import lif_pkg::*;
#(
  parameter int SYNAPSES       = 32,
  parameter int NEURONS        = 4,
  parameter int MEMBRANE_BITS  = 8,
  parameter int THRESHOLD_BITS = 6,
  parameter int REFRACTORY     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [1:0]                   load_sel,
  input  logic [$clog2(NEURONS)-1:0]   load_neuron,
  input  logic [7:0]                   load_data,
  input  logic                         tick,
  output logic                         busy,
  output logic                         step_done,
  output logic [NEURONS-1:0]           spikes
);

  localparam int IW = $clog2(NEURONS);
  localparam int CW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
  localparam int MB = MEMBRANE_BITS;

  logic [SYNAPSES-1:0]       r_inputs;
  logic [SYNAPSES-1:0]       r_weights [NEURONS];
  logic [THRESHOLD_BITS-1:0] r_thresh  [NEURONS];
  logic [2:0]                r_shift   [NEURONS];
  logic                      r_mode    [NEURONS];
  logic signed [MB-1:0]      r_mem     [NEURONS];
  logic [CW-1:0]             r_ref     [NEURONS];
  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [IW-1:0]             r_idx;
  logic [NEURONS-1:0]        r_shadow;
  logic [NEURONS-1:0]        r_spikes;
  logic                      r_step_done;

  logic                      w_load_fire;
  logic                      w_nsel_ok;
  logic signed [MB-1:0]      w_mem_nxt;
  logic                      w_spike;
  logic [CW-1:0]             w_ref_nxt;

  assign busy        = (r_state != ST_IDLE);
  assign load_ready  = !busy;
  assign spikes      = r_spikes;
  assign step_done   = r_step_done;
  assign w_load_fire = load_valid && load_ready;
  assign w_nsel_ok   = (int'(load_neuron) < NEURONS);

  // Byte loader: shift inputs/weights, write per-neuron config and threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inputs <= '0;
      for (int n = 0; n < NEURONS; n++) begin
        r_weights[n] <= WEIGHT_INIT[SYNAPSES-1:0];
        r_thresh[n]  <= THRESHOLD_BITS'(THRESH_INIT);
        r_shift[n]   <= 3'd0;
        r_mode[n]    <= 1'b0;
      end
    end else if (w_load_fire) begin
      case (load_sel)
        LD_INPUTS:  r_inputs <= (r_inputs << 8) | SYNAPSES'(load_data);
        LD_WEIGHTS: if (w_nsel_ok) r_weights[load_neuron] <= (r_weights[load_neuron] << 8) | SYNAPSES'(load_data);
        LD_CONFIG:  if (w_nsel_ok) begin
                      r_shift[load_neuron] <= load_data[2:0];
                      r_mode[load_neuron]  <= load_data[3];
                    end
        default:    if (w_nsel_ok) r_thresh[load_neuron] <= load_data[THRESHOLD_BITS-1:0];
      endcase
    end
  end

  // Sweep FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Sweep FSM next state: one EVAL cycle per neuron, then one DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (tick) w_state_nxt = ST_EVAL;
      ST_EVAL: if (r_idx == IW'(NEURONS - 1)) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  lif_update #(
    .SYNAPSES       (SYNAPSES),
    .MEMBRANE_BITS  (MEMBRANE_BITS),
    .THRESHOLD_BITS (THRESHOLD_BITS),
    .REFRACTORY     (REFRACTORY),
    .CW             (CW)
  ) u_update (
    .i_inputs  (r_inputs),
    .i_weights (r_weights[r_idx]),
    .i_mem     (r_mem[r_idx]),
    .i_shift   (r_shift[r_idx]),
    .i_mode    (r_mode[r_idx]),
    .i_thresh  (r_thresh[r_idx]),
    .i_ref     (r_ref[r_idx]),
    .o_mem     (w_mem_nxt),
    .o_spike   (w_spike),
    .o_ref     (w_ref_nxt)
  );

  // Neuron register file update, shadow spikes, and commit at end of sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NEURONS; n++) begin
        r_mem[n] <= '0;
        r_ref[n] <= '0;
      end
      r_idx       <= '0;
      r_shadow    <= '0;
      r_spikes    <= '0;
      r_step_done <= 1'b0;
    end else begin
      r_step_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (tick) r_idx <= '0;
        ST_EVAL: begin
          r_mem[r_idx]    <= w_mem_nxt;
          r_ref[r_idx]    <= w_ref_nxt;
          r_shadow[r_idx] <= w_spike;
          r_idx           <= r_idx + 1'b1;
        end
        ST_DONE: begin
          r_spikes    <= r_shadow;
          r_step_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
